uart_rx_cmd_parser: RTL and testbench

//  Consumes bytes from the RS-232 receiver stage: one rx_valid_i pulse per received byte, parallel data on rx_data_i.

---
 rtl/uart_rx_cmd_parser.sv | 143 ++++++++++++++
 tb/tb_uart_rx_cmd_parser.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_parser.sv
// Byte-stream command parser: SYNC, ADDR, DATA_HI, DATA_LO, CHK frames become register-write strobes.
// Optional saturating error counter on err_cnt_o is enabled by defining RXP_ERRCNT_EN.
module uart_rx_cmd_parser #(
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        wr_en_o,
   output logic [7:0]  wr_addr_o,
   output logic [15:0] wr_data_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
`ifdef RXP_ERRCNT_EN
   output logic [7:0]  err_cnt_o,
`endif
   output logic        busy_o
);

   localparam int unsigned    CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      S_ADDR,
      S_DHI,
      S_DLO,
      S_CHK
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tmo;
   logic              chk_bad;
   logic [7:0]        addr_q, dhi_q, dlo_q, chk_q;
   logic              wr_en_q, err_q, busy_q;
   logic [7:0]        wr_addr_q;
   logic [15:0]       wr_data_q;
   logic [1:0]        err_code_q;

   // A byte arriving on the terminal cycle clears the counter, so it always beats the timeout.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE || rx_valid_i) begin
         cnt_d = '0;
      end else if (cnt_q != TERM) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      tmo     = (state_q != IDLE) && !rx_valid_i && (cnt_d == TERM);
      chk_bad = rx_valid_i && (state_q == S_CHK) && (rx_data_i != chk_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         dhi_q      <= '0;
         dlo_q      <= '0;
         chk_q      <= '0;
         wr_en_q    <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         err_code_q <= '0;
      end else begin
         wr_en_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= cnt_d;
         if (tmo) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= 2'b10;
         end else if (rx_valid_i) begin
            case (state_q)
               IDLE: begin
                  if (rx_data_i == SYNC_BYTE) begin
                     state_q <= S_ADDR;
                     busy_q  <= 1'b1;
                  end
               end
               S_ADDR: begin
                  addr_q  <= rx_data_i;
                  chk_q   <= rx_data_i;
                  state_q <= S_DHI;
               end
               S_DHI: begin
                  dhi_q   <= rx_data_i;
                  chk_q   <= chk_q ^ rx_data_i;
                  state_q <= S_DLO;
               end
               S_DLO: begin
                  dlo_q   <= rx_data_i;
                  chk_q   <= chk_q ^ rx_data_i;
                  state_q <= S_CHK;
               end
               S_CHK: begin
                  if (chk_bad) begin
                     err_q      <= 1'b1;
                     err_code_q <= 2'b01;
                  end else begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= addr_q;
                     wr_data_q <= {dhi_q, dlo_q};
                  end
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef RXP_ERRCNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_cnt_q <= '0;
      end else if ((tmo || chk_bad) && err_cnt_q != 8'hFF) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign err_cnt_o = err_cnt_q;
`endif

   assign wr_en_o    = wr_en_q;
   assign wr_addr_o  = wr_addr_q;
   assign wr_data_o  = wr_data_q;
   assign err_o      = err_q;
   assign err_code_o = err_code_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Bench for uart_rx_cmd_parser: directed vector table, hand-written timing/reset sequences,
// and randomized frames checked against a byte-queue reference model (TIMEOUT_CYC=100).
module tb_uart_rx_cmd_parser;

   localparam int T = 100;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        wr_en_o;
   logic [7:0]  wr_addr_o;
   logic [15:0] wr_data_o;
   logic        err_o;
   logic [1:0]  err_code_o;
   logic        busy_o;
`ifdef RXP_ERRCNT_EN
   logic [7:0]  err_cnt_o;
`endif

   uart_rx_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(T)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .rx_data_i(rx_data_i),
      .rx_valid_i(rx_valid_i),
      .wr_en_o(wr_en_o),
      .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o),
      .err_o(err_o),
      .err_code_o(err_code_o),
`ifdef RXP_ERRCNT_EN
      .err_cnt_o(err_cnt_o),
`endif
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic ewr, input logic eerr, input logic ebusy,
                          input logic [7:0] eaddr, input logic [15:0] edata, input logic [1:0] ecode);
      chk({tag, ".wr_en"},    wr_en_o,    ewr);
      chk({tag, ".err"},      err_o,      eerr);
      chk({tag, ".busy"},     busy_o,     ebusy);
      chk({tag, ".wr_addr"},  wr_addr_o,  eaddr);
      chk({tag, ".wr_data"},  wr_data_o,  edata);
      chk({tag, ".err_code"}, err_code_o, ecode);
   endtask

   // Inputs change on the falling edge; each call leaves us one edge later with valid low.
   task automatic send(input logic [7:0] d);
      rx_valid_i = 1'b1;
      rx_data_i  = d;
      @(negedge clk_i);
      rx_valid_i = 1'b0;
   endtask

   // ---------------- reference model: a frame is a queue of accepted bytes ----------------
   logic [7:0]  mq[$];
   int          m_gap;
   logic        m_wr, m_err, m_busy;
   logic [7:0]  m_addr;
   logic [15:0] m_data;
   logic [1:0]  m_code;
   int          m_ecnt;

   function automatic void model_reset();
      mq.delete();
      m_gap = 0; m_wr = 0; m_err = 0; m_busy = 0;
      m_addr = '0; m_data = '0; m_code = '0; m_ecnt = 0;
   endfunction

   function automatic void model_step(input logic v, input logic [7:0] d);
      m_wr  = 1'b0;
      m_err = 1'b0;
      if (v) begin
         m_gap = 0;
         if (mq.size() != 0 || d == 8'hA5) mq.push_back(d);
         if (mq.size() == 5) begin
            if ((mq[1] ^ mq[2] ^ mq[3]) == mq[4]) begin
               m_wr   = 1'b1;
               m_addr = mq[1];
               m_data = {mq[2], mq[3]};
            end else begin
               m_err  = 1'b1;
               m_code = 2'b01;
            end
            mq.delete();
         end
      end else if (mq.size() != 0) begin
         m_gap++;
         if (m_gap == T - 1) begin
            m_err  = 1'b1;
            m_code = 2'b10;
            mq.delete();
            m_gap  = 0;
         end
      end
      m_busy = (mq.size() != 0);
      if (m_err && m_ecnt < 255) m_ecnt++;
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        ewr, eerr, ebusy;
      logic [7:0]  eaddr;
      logic [15:0] edata;
      logic [1:0]  ecode;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic v, input logic [7:0] d, input logic ewr, input logic eerr,
                               input logic ebusy, input logic [7:0] ea, input logic [15:0] ed,
                               input logic [1:0] ec);
      vec_t e;
      e.v = v; e.d = d; e.ewr = ewr; e.eerr = eerr; e.ebusy = ebusy;
      e.eaddr = ea; e.edata = ed; e.ecode = ec;
      tbl.push_back(e);
   endfunction

   logic [7:0] pd[$];
   logic       pv[$];

   task automatic plan_byte(input logic [7:0] d, input int gap);
      pv.push_back(1'b1);
      pd.push_back(d);
      for (int g = 0; g < gap; g++) begin
         pv.push_back(1'b0);
         pd.push_back(8'($urandom));
      end
   endtask

   initial begin
      int k;
      int errs;
      logic [7:0] a, h, l, c;
      int r, n;
      int gaps[5];

      // valid frame
      add(1, 8'hA5, 0, 0, 1, 8'h00, 16'h0000, 2'b00);
      add(1, 8'h12, 0, 0, 1, 8'h00, 16'h0000, 2'b00);
      add(1, 8'h34, 0, 0, 1, 8'h00, 16'h0000, 2'b00);
      add(1, 8'h56, 0, 0, 1, 8'h00, 16'h0000, 2'b00);
      add(1, 8'h70, 1, 0, 0, 8'h12, 16'h3456, 2'b00);
      add(0, 8'h00, 0, 0, 0, 8'h12, 16'h3456, 2'b00);
      // bad checksum
      add(1, 8'hA5, 0, 0, 1, 8'h12, 16'h3456, 2'b00);
      add(1, 8'h12, 0, 0, 1, 8'h12, 16'h3456, 2'b00);
      add(1, 8'h34, 0, 0, 1, 8'h12, 16'h3456, 2'b00);
      add(1, 8'h56, 0, 0, 1, 8'h12, 16'h3456, 2'b00);
      add(1, 8'h71, 0, 1, 0, 8'h12, 16'h3456, 2'b01);
      add(0, 8'h00, 0, 0, 0, 8'h12, 16'h3456, 2'b01);
      // garbage then valid frame
      add(1, 8'h00, 0, 0, 0, 8'h12, 16'h3456, 2'b01);
      add(1, 8'hFF, 0, 0, 0, 8'h12, 16'h3456, 2'b01);
      add(1, 8'h5A, 0, 0, 0, 8'h12, 16'h3456, 2'b01);
      add(1, 8'hA5, 0, 0, 1, 8'h12, 16'h3456, 2'b01);
      add(1, 8'h01, 0, 0, 1, 8'h12, 16'h3456, 2'b01);
      add(1, 8'h02, 0, 0, 1, 8'h12, 16'h3456, 2'b01);
      add(1, 8'h03, 0, 0, 1, 8'h12, 16'h3456, 2'b01);
      add(1, 8'h00, 1, 0, 0, 8'h01, 16'h0203, 2'b01);
      // SYNC value as payload, back-to-back
      add(1, 8'hA5, 0, 0, 1, 8'h01, 16'h0203, 2'b01);
      add(1, 8'hA5, 0, 0, 1, 8'h01, 16'h0203, 2'b01);
      add(1, 8'h00, 0, 0, 1, 8'h01, 16'h0203, 2'b01);
      add(1, 8'h00, 0, 0, 1, 8'h01, 16'h0203, 2'b01);
      add(1, 8'hA5, 1, 0, 0, 8'hA5, 16'h0000, 2'b01);
      add(0, 8'h00, 0, 0, 0, 8'hA5, 16'h0000, 2'b01);

      rst_i      = 1'b1;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      repeat (3) @(negedge clk_i);
      chk_all("reset", 0, 0, 0, 8'h00, 16'h0000, 2'b00);
`ifdef RXP_ERRCNT_EN
      chk("reset.err_cnt", err_cnt_o, 8'h00);
`endif
      rst_i = 1'b0;
      @(negedge clk_i);

      for (int i = 0; i < tbl.size(); i++) begin
         rx_valid_i = tbl[i].v;
         rx_data_i  = tbl[i].d;
         @(negedge clk_i);
         chk_all($sformatf("tbl[%0d]", i), tbl[i].ewr, tbl[i].eerr, tbl[i].ebusy,
                 tbl[i].eaddr, tbl[i].edata, tbl[i].ecode);
      end
      rx_valid_i = 1'b0;

      // timeout: error exactly T-1 edges after the edge that took the last byte
      send(8'hA5);
      send(8'h12);
      k = 0;
      for (int e = 1; e <= 150; e++) begin
         @(negedge clk_i);
         if (err_o === 1'b1) begin
            k = e;
            break;
         end
      end
      chk("timeout.latency", k, T - 1);
      chk("timeout.code", err_code_o, 2'b10);
      chk("timeout.busy", busy_o, 1'b0);
      @(negedge clk_i);
      chk("timeout.pulse", err_o, 1'b0);
      send(8'hA5); send(8'h21); send(8'h43); send(8'h65); send(8'h07);
      chk_all("after_tmo", 1, 0, 0, 8'h21, 16'h4365, 2'b10);

      // byte arriving on the terminal cycle beats the timeout
      send(8'hA5);
      send(8'h12);
      errs = 0;
      for (int e = 1; e <= T - 2; e++) begin
         @(negedge clk_i);
         if (err_o === 1'b1) errs++;
      end
      send(8'h34);
      chk("collide.err", err_o, 1'b0);
      chk("collide.early_err", errs, 0);
      chk("collide.busy", busy_o, 1'b1);
      send(8'h56); send(8'h70);
      chk_all("collide.frame", 1, 0, 0, 8'h12, 16'h3456, 2'b10);

      // asynchronous reset mid-frame loses the partial frame
      send(8'hA5); send(8'h12); send(8'h34);
      #2 rst_i = 1'b1;
      #1;
      chk_all("async_rst", 0, 0, 0, 8'h00, 16'h0000, 2'b00);
      @(negedge clk_i);
      rst_i = 1'b0;
      send(8'h56);
      chk_all("post_rst.56", 0, 0, 0, 8'h00, 16'h0000, 2'b00);
      send(8'h70);
      chk_all("post_rst.70", 0, 0, 0, 8'h00, 16'h0000, 2'b00);

`ifdef RXP_ERRCNT_EN
      for (int f = 0; f < 300; f++) begin
         send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
      end
      chk("errcnt.sat", err_cnt_o, 8'hFF);
`endif

      // randomized frames against the reference model
      gaps = '{T - 3, T - 2, T - 1, T, T + 20};
      for (int f = 0; f < 160; f++) begin
         r = $urandom_range(0, 9);
         a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
         c = a ^ h ^ l;
         if (r < 6) begin
            plan_byte(8'hA5, $urandom_range(0, 2)); plan_byte(a, $urandom_range(0, 2));
            plan_byte(h, $urandom_range(0, 2));     plan_byte(l, $urandom_range(0, 2));
            plan_byte(c, $urandom_range(0, 3));
         end else if (r == 6) begin
            plan_byte(8'hA5, 0); plan_byte(a, 1); plan_byte(h, 0); plan_byte(l, 0);
            plan_byte(c ^ 8'($urandom_range(1, 255)), 1);
         end else if (r == 7) begin
            n = $urandom_range(1, 3);
            for (int b = 0; b < n; b++) plan_byte(8'($urandom), $urandom_range(0, 1));
         end else begin
            n = $urandom_range(0, 3);
            plan_byte(8'hA5, (n == 0) ? gaps[$urandom_range(0, 4)] : 0);
            for (int b = 0; b < n; b++)
               plan_byte(8'($urandom), (b == n - 1) ? gaps[$urandom_range(0, 4)] : 0);
         end
      end
      plan_byte(8'h00, T + 5);

      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();
      for (int i = 0; i < pv.size(); i++) begin
         rx_valid_i = pv[i];
         rx_data_i  = pd[i];
         model_step(pv[i], pd[i]);
         @(negedge clk_i);
         chk_all($sformatf("rand[%0d]", i), m_wr, m_err, m_busy, m_addr, m_data, m_code);
`ifdef RXP_ERRCNT_EN
         chk($sformatf("rand[%0d].err_cnt", i), err_cnt_o, 8'(m_ecnt));
`endif
      end
      rx_valid_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
